// File: rtl/wave_sel_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// wave_sel_ctrl_pkg
// Shared definitions for the waveform selector and the DDS address stage.
//   CNT_W            : width of the per-key debounce counter
//   CNT_MAX_DEFAULT  : stable-low count for a valid press (20 ms at 50 MHz)
//   WAVE_*           : one-hot waveform select codes
//   wave_from_flags  : priority select, lowest key index wins
// ---------------------------------------------------------------------------
package wave_sel_ctrl_pkg;

  localparam int          CNT_W           = 20;
  localparam logic [19:0] CNT_MAX_DEFAULT = 20'd999_999;

  localparam logic [3:0] WAVE_SINE   = 4'b0001;
  localparam logic [3:0] WAVE_SQUARE = 4'b0010;
  localparam logic [3:0] WAVE_TRI    = 4'b0100;
  localparam logic [3:0] WAVE_SAW    = 4'b1000;

  // Key 0 has the highest priority; with no pulse the current code is kept,
  // so re-pressing the active waveform never disturbs the output.
  function automatic logic [3:0] wave_from_flags(input logic [3:0] flags,
                                                 input logic [3:0] current);
    logic [3:0] result;
    result = current;
    if (flags[0])      result = WAVE_SINE;
    else if (flags[1]) result = WAVE_SQUARE;
    else if (flags[2]) result = WAVE_TRI;
    else if (flags[3]) result = WAVE_SAW;
    return result;
  endfunction

endpackage

// File: rtl/wave_sel_ctrl_key_filter.sv
// ---------------------------------------------------------------------------
// key_filter
// Debounces one active-low push button and emits a single-cycle pulse per
// accepted press.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   key_in    : raw key, active-low, asynchronous to sys_clk
//   key_flag  : registered one-cycle pulse when the press is accepted
// ---------------------------------------------------------------------------
module key_filter
  import wave_sel_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag
);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;

  // Two-flop synchronizer; resets to the released (high) level so that a
  // key held through reset looks like a fresh press afterwards.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Stable-low counter: any high sample restarts it, and it parks at
  // CNT_MAX so a held key cannot re-trigger.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (r_sync2) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The counter passes CNT_MAX-1 only once per press, which makes the
  // flag a natural single-cycle pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_flag <= 1'b0;
    end else begin
      r_flag <= ~r_sync2 && (r_cnt == CNT_MAX - 1'b1);
    end
  end

  assign key_flag = r_flag;

endmodule

// File: rtl/wave_sel_ctrl.sv
// ---------------------------------------------------------------------------
// wave_sel_ctrl
// Four debounced keys pick the DDS waveform.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   key_in    : raw keys, active-low; bit i requests waveform i
//   wave_sel  : registered one-hot waveform select (sine after reset)
//   key_flag  : registered one-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module wave_sel_ctrl
  import wave_sel_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEFAULT,
  parameter int               KEY_W   = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [3:0]       wave_sel,
  output logic [KEY_W-1:0] key_flag
);

  logic [KEY_W-1:0] w_key_flag;
  logic [3:0]       r_wave_sel;

  // One independent debouncer per key.
  for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
    key_filter #(
      .CNT_MAX (CNT_MAX)
    ) u_key_filter (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_in    (key_in[gi]),
      .key_flag  (w_key_flag[gi])
    );
  end

  // The register only ever loads a package code or its own value, so it
  // stays one-hot from reset onward.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wave_sel <= WAVE_SINE;
    end else begin
      r_wave_sel <= wave_from_flags(w_key_flag, r_wave_sel);
    end
  end

  assign wave_sel = r_wave_sel;
  assign key_flag = w_key_flag;

endmodule

// File: tb/tb_wave_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wave_sel_ctrl
// Self-checking bench for wave_sel_ctrl with CNT_MAX = 10. Directed
// scenarios followed by random key activity, all compared every cycle
// against a sample-history reference model.
// ---------------------------------------------------------------------------
module tb_wave_sel_ctrl;

  localparam int CNT_MAX = 10;

  logic       sysClk;
  logic       sysRstN;
  logic [3:0] keyIn;
  logic [3:0] waveSel;
  logic [3:0] keyFlag;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state: per-key history of synchronized-input samples.
  bit         hist [4][$];
  logic [3:0] expFlag;
  logic [3:0] expWave;

  int tickNum;
  int pulseCnt   [4];
  int firstPulse [4];

  wave_sel_ctrl #(
    .CNT_MAX (20'd10),
    .KEY_W   (4)
  ) dut (
    .sys_clk   (sysClk),
    .sys_rst_n (sysRstN),
    .key_in    (keyIn),
    .wave_sel  (waveSel),
    .key_flag  (keyFlag)
  );

  // Free-running 100 MHz clock.
  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  // Reset puts two released samples in front of the history, matching the
  // synchronizer's reset level.
  task automatic modelReset();
    for (int k = 0; k < 4; k++) begin
      hist[k].delete();
      hist[k].push_back(1'b1);
      hist[k].push_back(1'b1);
    end
    expFlag = 4'b0000;
    expWave = 4'b0001;
  endtask

  // A press is accepted when the run of low samples ending two samples ago
  // is exactly CNT_MAX long (synchronizer delay + stable count).
  function automatic int lowRun(int k);
    int n;
    n = 0;
    for (int j = hist[k].size() - 3; j >= 0; j--) begin
      if (hist[k][j]) break;
      n++;
      if (n > CNT_MAX) break;
    end
    return n;
  endfunction

  // Advance the model by one rising edge.
  task automatic modelStep();
    logic [3:0] newWave;
    if (!sysRstN) begin
      modelReset();
    end else begin
      newWave = expWave;
      for (int k = 3; k >= 0; k--) begin
        if (expFlag[k]) newWave = 4'(1 << k);
      end
      for (int k = 0; k < 4; k++) begin
        hist[k].push_back(keyIn[k]);
        if (hist[k].size() > 64) void'(hist[k].pop_front());
        expFlag[k] = (lowRun(k) == CNT_MAX);
      end
      expWave = newWave;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic checkOutput(input string tag);
    assertCount++;
    assert (keyFlag === expFlag) else begin
      failCount++;
      $error("[TB] FAIL %s key_flag observed=%b expected=%b", tag, keyFlag, expFlag);
    end
    assertCount++;
    assert (waveSel === expWave) else begin
      failCount++;
      $error("[TB] FAIL %s wave_sel observed=%b expected=%b", tag, waveSel, expWave);
    end
    assertCount++;
    assert ($onehot(waveSel) === 1'b1) else begin
      failCount++;
      $error("[TB] FAIL %s wave_sel_onehot observed=%b expected=one-hot", tag, waveSel);
    end
  endtask

  // Scenario-level comparison of a derived quantity against a fixed value.
  task automatic checkValue(input string tag, input int observed, input int expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearPulse();
    tickNum = 0;
    for (int k = 0; k < 4; k++) begin
      pulseCnt[k]   = 0;
      firstPulse[k] = -1;
    end
  endtask

  // Drive keys at the falling edge, step the model on the rising edge and
  // compare on the next falling edge.
  task automatic applyStimulus(input logic [3:0] keys, input int cycles, input string tag);
    keyIn = keys;
    for (int c = 0; c < cycles; c++) begin
      @(posedge sysClk);
      modelStep();
      @(negedge sysClk);
      tickNum++;
      checkOutput(tag);
      for (int k = 0; k < 4; k++) begin
        if (keyFlag[k] === 1'b1) begin
          pulseCnt[k]++;
          if (firstPulse[k] < 0) firstPulse[k] = tickNum;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] rndKeys;

    keyIn   = 4'hF;
    sysRstN = 1'b1;
    clearPulse();
    #3;
    sysRstN = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_async");
    @(negedge sysClk);
    applyStimulus(4'hF, 3, "reset_hold");
    sysRstN = 1'b1;

    $display("[TB] idle after reset");
    applyStimulus(4'hF, 100, "idle");

    $display("[TB] key2 held");
    clearPulse();
    applyStimulus(4'b1011, 50, "key2_hold");
    checkValue("key2_first_pulse", firstPulse[2], 12);
    checkValue("key2_pulse_count", pulseCnt[2], 1);
    checkValue("key2_wave", int'(waveSel), 4);
    applyStimulus(4'hF, 5, "release");

    $display("[TB] key1 bounce");
    clearPulse();
    for (int b = 0; b < 3; b++) begin
      applyStimulus(4'b1101, 5, "key1_bounce_low");
      applyStimulus(4'b1111, 1, "key1_bounce_high");
    end
    applyStimulus(4'b1101, 20, "key1_stable");
    checkValue("key1_pulse_count", pulseCnt[1], 1);
    checkValue("key1_first_pulse", firstPulse[1], 30);
    checkValue("key1_wave", int'(waveSel), 2);
    applyStimulus(4'hF, 5, "release");

    $display("[TB] key3 and key0 together");
    clearPulse();
    applyStimulus(4'b0110, 20, "key30_hold");
    checkValue("key0_first_pulse", firstPulse[0], 12);
    checkValue("key3_first_pulse", firstPulse[3], 12);
    checkValue("key30_wave", int'(waveSel), 1);
    applyStimulus(4'hF, 5, "release");

    $display("[TB] key3 reselect");
    applyStimulus(4'b0111, 20, "key3_first");
    checkValue("key3_wave_first", int'(waveSel), 8);
    applyStimulus(4'hF, 5, "release");
    clearPulse();
    applyStimulus(4'b0111, 20, "key3_again");
    checkValue("key3_again_pulse_count", pulseCnt[3], 1);
    checkValue("key3_again_wave", int'(waveSel), 8);
    applyStimulus(4'hF, 5, "release");

    $display("[TB] reset mid-count");
    applyStimulus(4'b1011, 8, "key2_precount");
    sysRstN = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_midcount");
    checkValue("reset_wave", int'(waveSel), 1);
    applyStimulus(4'b1011, 3, "reset_midcount_hold");
    sysRstN = 1'b1;
    clearPulse();
    applyStimulus(4'b1011, 30, "key2_after_reset");
    checkValue("key2_reset_first_pulse", firstPulse[2], 12);
    checkValue("key2_reset_pulse_count", pulseCnt[2], 1);
    checkValue("key2_reset_wave", int'(waveSel), 4);
    applyStimulus(4'hF, 5, "release");

    $display("[TB] random key activity");
    rndKeys = 4'hF;
    for (int r = 0; r < 3000; r++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(15) == 0) rndKeys[k] = ~rndKeys[k];
      end
      applyStimulus(rndKeys, 1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/wave_sel_ctrl.md
WAVE_SEL_CTRL -- requirements
Module: wave_sel_ctrl

Interface
REQ-001 SHALL have parameter CNT_MAX, default 20'd999_999, debounce stable-low count (20 ms at 50 MHz).
REQ-002 SHALL have parameter KEY_W, default 4, number of keys (fixed 4 in this design).
REQ-003 sys_clk  input  1  single system clock; all logic rising-edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 key_in  input  4  raw push-buttons, active-low, asynchronous to sys_clk; bit i requests waveform i.
REQ-006 wave_sel  output  4  registered one-hot waveform select feeding the DDS stage (0001 sine, 0010 square, 0100 triangle, 1000 sawtooth).
REQ-007 key_flag  output  4  registered one-cycle pulse per accepted key press, bit i for key i.

Function
REQ-008 Each key_in bit SHALL pass through a 2-flop synchronizer; all further logic uses the synchronized value only.
REQ-009 Each key SHALL own a 20-bit counter: cleared to 0 in any cycle the synchronized key is high.
REQ-010 While the synchronized key is low, the counter SHALL increment by 1 per cycle and saturate at CNT_MAX (no wrap).
REQ-011 key_flag[i] SHALL be 1 for exactly one cycle: the cycle after counter i equals CNT_MAX-1 with key still low; otherwise 0.
REQ-012 A key held indefinitely SHALL yield exactly one key_flag pulse; a new pulse requires release (counter clear) and a fresh full count.
REQ-013 Any high sample (bounce) before CNT_MAX-1 is reached SHALL clear the counter and produce no pulse.
REQ-014 wave_sel SHALL update the cycle after any key_flag pulse to the one-hot code of the pulsing key.
REQ-015 Simultaneous key_flag pulses SHALL select the lowest-index key (bit 0 highest priority).
REQ-016 A pulse for the currently selected waveform SHALL leave wave_sel unchanged; no glitch.
REQ-017 wave_sel SHALL always be exactly one-hot; no other code is ever driven.
REQ-018 Latency: first low sample at key_in pin to wave_sel change = 2 (sync) + CNT_MAX + 1 cycles, assuming no bounce.
REQ-019 Keys SHALL debounce independently; activity on one key does not affect another key's counter.

Reset
REQ-020 On sys_rst_n low, asynchronously: synchronizer flops to 1 (released), counters to 0, key_flag to 4'b0000, wave_sel to 4'b0001 (sine).
REQ-021 Reset asserted mid-count SHALL discard the pending press; after deassertion a held key SHALL require a full CNT_MAX count before pulsing.
REQ-022 Reset deassertion SHALL produce no spurious key_flag pulse, including with keys held low.

Structure
REQ-023 Wave one-hot codes (WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW) and default CNT_MAX SHALL be in the shared package, also used by the DDS address stage.
REQ-024 Per-key synchronizer + counter + flag SHALL be one sub-module, key_filter, instantiated 4 times; priority select and wave_sel register stay in wave_sel_ctrl.

Verification (CNT_MAX overridden to 10)
REQ-025 After reset, all keys high -> wave_sel=0001, key_flag=0000 for 100 cycles.
REQ-026 key_in[2] low, held 50 cycles -> key_flag[2] single pulse 12 cycles after first low; wave_sel=0100 one cycle later; no second pulse.
REQ-027 key_in[1] toggles low 5 / high 1 cycle x3, then low 20 -> exactly one key_flag[1] pulse, only after the stable 20-cycle segment; wave_sel=0010.
REQ-028 key_in[3] and key_in[0] low on the same cycle -> both flags pulse together; wave_sel=0001.
REQ-029 wave_sel=1000; key_in[3] pressed again -> key_flag[3] pulses; wave_sel stays 1000.
REQ-030 key_in[2] low, reset asserted at count 6, released, key still low -> wave_sel=0001 after reset; pulse only 12 cycles after deassertion, then wave_sel=0100.
